// File: rtl/autoreset_drv_pkg.sv
// Shared state encoding, default widths and small helpers for the autoreset operand sequencer.
package autoreset_drv_pkg;

    localparam int DEF_A_W      = 30;
    localparam int DEF_B_W      = 18;
    localparam int DEF_P_W      = 48;
    localparam int DEF_FRM_W    = 8;
    localparam int DEF_PIPE_LAT = 3;
    localparam int DEF_TO_CYC   = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FAIL  = 3'd4
    } state_e;

    // A new run may only be launched from a parked state.
    function automatic logic can_start(input state_e s);
        return (s == ST_IDLE) || (s == ST_FAIL);
    endfunction

endpackage

// File: rtl/autoreset_drv_if.sv
// Control/slice bundle of the autoreset sequencer; MISMATCH exists only with AUTORESET_DRV_CHECK_EN.
interface autoreset_drv_if
    import autoreset_drv_pkg::*;
#(
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int P_W   = DEF_P_W,
    parameter int FRM_W = DEF_FRM_W
);
    logic             START;
    logic [FRM_W-1:0] NUM_FRAMES;
    logic [P_W-1:0]   TARGET;
    logic [A_W-1:0]   A_SEED;
    logic [B_W-1:0]   B_SEED;
    logic             AUTORESET_IN;
    logic [A_W-1:0]   A_OUT;
    logic [B_W-1:0]   B_OUT;
    logic [P_W-1:0]   C_OUT;
    logic             OP_VALID;
    logic             BUSY;
    logic             DONE;
    logic             ERR;
    logic [FRM_W-1:0] FRAME_CNT;
`ifdef AUTORESET_DRV_CHECK_EN
    logic             MISMATCH;
`endif

    modport master (
        output START, NUM_FRAMES, TARGET, A_SEED, B_SEED, AUTORESET_IN,
        input  A_OUT, B_OUT, C_OUT, OP_VALID, BUSY, DONE, ERR, FRAME_CNT
`ifdef AUTORESET_DRV_CHECK_EN
        , input MISMATCH
`endif
    );

    modport slave (
        input  START, NUM_FRAMES, TARGET, A_SEED, B_SEED, AUTORESET_IN,
        output A_OUT, B_OUT, C_OUT, OP_VALID, BUSY, DONE, ERR, FRAME_CNT
`ifdef AUTORESET_DRV_CHECK_EN
        , output MISMATCH
`endif
    );

endinterface

// File: rtl/autoreset_drv_chk.sv
// Shadow accumulator and expected-autoreset delay line; built only with AUTORESET_DRV_CHECK_EN.
module autoreset_chk
    import autoreset_drv_pkg::*;
#(
    parameter int A_W      = DEF_A_W,
    parameter int B_W      = DEF_B_W,
    parameter int P_W      = DEF_P_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_clr,
    input  logic           load,
    input  logic           run,
    input  logic           op_valid,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic [P_W-1:0] target,
    input  logic           autoreset_in,
    output logic           mismatch
);
    logic [P_W-1:0]      acc_q;
    logic [P_W-1:0]      acc_d;
    logic [P_W-1:0]      prod_s;
    logic [P_W-1:0]      sum_s;
    logic [PIPE_LAT-1:0] dl_q;
    logic [PIPE_LAT-1:0] dl_d;
    logic                hit_s;
    logic                mismatch_q;
    logic                mismatch_d;

    // Next-state of the shadow MAC, the delay line and the sticky compare flag
    always_comb begin
        prod_s     = P_W'(a) * P_W'(b);
        sum_s      = acc_q + prod_s;
        hit_s      = op_valid && (sum_s == target);
        acc_d      = acc_q;
        dl_d       = PIPE_LAT'({dl_q, hit_s});
        mismatch_d = mismatch_q;
        if (load) begin
            acc_d = '0;
            dl_d  = '0;
        end else if (op_valid) begin
            acc_d = hit_s ? '0 : sum_s;
        end else begin
            acc_d = acc_q;
        end
        // Only RUN compares: pulses landing in DRAIN belong to flushed operands.
        if (start_clr) begin
            mismatch_d = 1'b0;
        end else if (run && (autoreset_in != dl_q[PIPE_LAT-1])) begin
            mismatch_d = 1'b1;
        end else begin
            mismatch_d = mismatch_q;
        end
    end

    // Checker state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            dl_q       <= '0;
            mismatch_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            dl_q       <= dl_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;

endmodule

// File: rtl/autoreset_drv.sv
// Operand sequencer for the DSP48E accumulate/pattern-detect/autoreset slice.
// Define AUTORESET_DRV_CHECK_EN to add the shadow checker and the MISMATCH flag.
module autoreset_drv
    import autoreset_drv_pkg::*;
#(
    parameter int A_W      = DEF_A_W,
    parameter int B_W      = DEF_B_W,
    parameter int P_W      = DEF_P_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int FRM_W    = DEF_FRM_W,
    parameter int TO_CYC   = DEF_TO_CYC
) (
    input logic            CLK,
    input logic            RST,
    autoreset_drv_if.slave bus
);
    localparam int CYC_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam int DR_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    state_e           state_q,     state_d;
    logic [P_W-1:0]   target_q,    target_d;
    logic [A_W-1:0]   a_q,         a_d;
    logic [B_W-1:0]   b_q,         b_d;
    logic [FRM_W-1:0] num_q,       num_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CYC_W-1:0] cyc_q,       cyc_d;
    logic [DR_W-1:0]  drain_q,     drain_d;
    logic             last_q,      last_d;
    logic             op_valid_q,  op_valid_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             err_q,       err_d;
    logic             start_ok_s;
    logic [FRM_W-1:0] frame_inc_s;

    assign start_ok_s  = bus.START && can_start(state_q);
    assign frame_inc_s = frame_cnt_q + FRM_W'(1);

    // Sequencer next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        a_d         = a_q;
        b_d         = b_q;
        num_d       = num_q;
        frame_cnt_d = frame_cnt_q;
        cyc_d       = cyc_q;
        drain_d     = drain_q;
        last_d      = last_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (start_ok_s) begin
                    target_d    = bus.TARGET;
                    a_d         = bus.A_SEED;
                    b_d         = bus.B_SEED;
                    num_d       = (bus.NUM_FRAMES == '0) ? FRM_W'(1) : bus.NUM_FRAMES;
                    frame_cnt_d = '0;
                    err_d       = 1'b0;
                    last_d      = 1'b0;
                    state_d     = ST_LOAD;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                cyc_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A pulse on the timeout cycle still closes the frame.
                if (bus.AUTORESET_IN) begin
                    frame_cnt_d = frame_inc_s;
                    drain_d     = DR_W'(PIPE_LAT - 1);
                    state_d     = ST_DRAIN;
                    if (frame_inc_s == num_q) begin
                        done_d = 1'b1;
                        last_d = 1'b1;
                    end else begin
                        last_d = 1'b0;
                    end
                end else if (cyc_q == CYC_W'(TO_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_FAIL;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        cyc_d   = '0;
                        state_d = ST_RUN;
                    end
                end else begin
                    drain_d = drain_q - DR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        op_valid_d = (state_d == ST_RUN);
        busy_d     = (state_d != ST_IDLE);
    end

    // State, captured operands, counters and output flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            num_q       <= '0;
            frame_cnt_q <= '0;
            cyc_q       <= '0;
            drain_q     <= '0;
            last_q      <= 1'b0;
            op_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            a_q         <= a_d;
            b_q         <= b_d;
            num_q       <= num_d;
            frame_cnt_q <= frame_cnt_d;
            cyc_q       <= cyc_d;
            drain_q     <= drain_d;
            last_q      <= last_d;
            op_valid_q  <= op_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.A_OUT     = a_q;
    assign bus.B_OUT     = b_q;
    assign bus.C_OUT     = target_q;
    assign bus.OP_VALID  = op_valid_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
    assign bus.FRAME_CNT = frame_cnt_q;

`ifdef AUTORESET_DRV_CHECK_EN
    autoreset_chk #(
        .A_W      (A_W),
        .B_W      (B_W),
        .P_W      (P_W),
        .PIPE_LAT (PIPE_LAT)
    ) u_chk (
        .clk          (CLK),
        .rst_n        (RST),
        .start_clr    (start_ok_s),
        .load         (state_q == ST_LOAD),
        .run          (state_q == ST_RUN),
        .op_valid     (op_valid_q),
        .a            (a_q),
        .b            (b_q),
        .target       (target_q),
        .autoreset_in (bus.AUTORESET_IN),
        .mismatch     (bus.MISMATCH)
    );
`endif

endmodule
